// File: rtl/display_shifter_pkg.sv
// Shared definitions for the seven-segment frame serialiser: segment codes,
// controller states and the frame size.
package display_pkg;

  localparam int FRAME_BITS = 48;

  // Segment bytes are {dp,g,f,e,d,c,b,a}, 1 = lit.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  function automatic logic [7:0] seg_code(input logic [3:0] bcd);
    logic [7:0] code;
    case (bcd)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/display_shifter_bcd_to_seg.sv
// One digit of the frame: BCD value to seven-segment byte with the DP bit
// supplied by the caller.
module bcd_to_seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  assign code = seg_code(bcd);
  assign seg  = {dp, code[6:0]};

endmodule

// File: rtl/display_shifter.sv
// Serialises the six time-of-day digits into a 48-bit seven-segment frame for
// a chain of external latching shift registers (sclk/sdata/latch).
module display_shifter
  import display_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       update_i,
  input  logic       colon_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] min_h_i,
  input  logic [3:0] min_l_i,
  input  logic [2:0] sec_h_i,
  input  logic [3:0] sec_l_i,
  output logic       sclk_o,
  output logic       sdata_o,
  output logic       latch_o,
  output logic       busy_o,
  output state_t     state_o
);

  localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_FIRST  = 6'(FRAME_BITS - 1);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [5:0]  bit_q, bit_d;
  logic [47:0] sreg_q, sreg_d;
  logic        pending_q, pending_d;
  logic        phase_done;

  logic [7:0]  seg_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl;
  logic [7:0]  byte_hh;
  logic [47:0] frame;

  bcd_to_seg u_hh (.bcd({2'b00, hour_h_i}), .dp(1'b0),    .seg(seg_hh));
  bcd_to_seg u_hl (.bcd(hour_l_i),          .dp(colon_i), .seg(seg_hl));
  bcd_to_seg u_mh (.bcd({1'b0, min_h_i}),   .dp(1'b0),    .seg(seg_mh));
  bcd_to_seg u_ml (.bcd(min_l_i),           .dp(colon_i), .seg(seg_ml));
  bcd_to_seg u_sh (.bcd({1'b0, sec_h_i}),   .dp(1'b0),    .seg(seg_sh));
  bcd_to_seg u_sl (.bcd(sec_l_i),           .dp(1'b0),    .seg(seg_sl));

  assign byte_hh    = (BLANK_LZ && (hour_h_i == 2'd0)) ? SEG_BLANK : seg_hh;
  assign frame      = {byte_hh, seg_hl, seg_mh, seg_ml, seg_sh, seg_sl};
  assign phase_done = (phase_q == PHASE_LAST);
  assign state_o    = state_q;

  // Handshake: update_i is a one-cycle request with no ready; a request that
  // arrives while a frame is in flight is remembered in pending and several
  // such requests collapse into one follow-up frame.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    sreg_d    = sreg_q;
    pending_d = pending_q | (update_i && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (update_i || pending_q) state_d = LOAD;
      end
      LOAD: begin
        sreg_d  = frame;
        bit_d   = BIT_FIRST;
        phase_d = 8'd0;
        state_d = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (phase_done) begin
          phase_d = 8'd0;
          state_d = SHIFT_HI;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (phase_done) begin
          phase_d = 8'd0;
          sreg_d  = {sreg_q[46:0], 1'b0};
          if (bit_q == 6'd0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 6'd1;
            state_d = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      LATCH: begin
        if (phase_done) begin
          phase_d = 8'd0;
          // Going straight to LOAD avoids an idle gap between frames.
          state_d = (pending_q || update_i) ? LOAD : IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      phase_q   <= 8'd0;
      bit_q     <= 6'd0;
      sreg_q    <= 48'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      sreg_q    <= sreg_d;
      pending_q <= pending_d;
    end
  end

  // Outputs are registered from the next state so the pins line up with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_o  <= 1'b0;
      sdata_o <= 1'b0;
      latch_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      sclk_o  <= (state_d == SHIFT_HI);
      sdata_o <= ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) && sreg_d[47];
      latch_o <= (state_d == LATCH);
      busy_o  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_display_shifter.sv
// Bench for display_shifter: two instances (CLK_DIV=1/BLANK_LZ=1 and
// CLK_DIV=3/BLANK_LZ=0) checked every cycle against a frame-position model.
module tb_display_shifter;
  import display_pkg::*;

  localparam int DIV0 = 1;
  localparam int DIV1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       update = 1'b0;
  logic       colon = 1'b0;
  logic [1:0] hh = '0;
  logic [3:0] hl = '0;
  logic [2:0] mh = '0;
  logic [3:0] ml = '0;
  logic [2:0] sh = '0;
  logic [3:0] sl = '0;

  logic   sclk[2], sdata[2], latch[2], busy[2];
  state_t dbg_state[2];

  display_shifter #(.CLK_DIV(DIV0), .BLANK_LZ(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .update_i(update), .colon_i(colon),
    .hour_h_i(hh), .hour_l_i(hl), .min_h_i(mh), .min_l_i(ml), .sec_h_i(sh), .sec_l_i(sl),
    .sclk_o(sclk[0]), .sdata_o(sdata[0]), .latch_o(latch[0]), .busy_o(busy[0]),
    .state_o(dbg_state[0])
  );

  display_shifter #(.CLK_DIV(DIV1), .BLANK_LZ(1'b0)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .update_i(update), .colon_i(colon),
    .hour_h_i(hh), .hour_l_i(hl), .min_h_i(mh), .min_l_i(ml), .sec_h_i(sh), .sec_l_i(sl),
    .sclk_o(sclk[1]), .sdata_o(sdata[1]), .latch_o(latch[1]), .busy_o(busy[1]),
    .state_o(dbg_state[1])
  );

  // ---------------- model ----------------
  function automatic logic [7:0] seg7(input int v);
    case (v)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;
      default: return 8'h40;
    endcase
  endfunction

  function automatic logic [47:0] frame_of(input bit blz);
    logic [7:0] b5, b4, b2;
    b5 = (blz && hh == 2'd0) ? 8'h00 : seg7(int'(hh));
    b4 = seg7(int'(hl)) | {colon, 7'b0};
    b2 = seg7(int'(ml)) | {colon, 7'b0};
    return {b5, b4, seg7(int'(mh)), b2, seg7(int'(sh)), seg7(int'(sl))};
  endfunction

  int          checks = 0;
  int          errors = 0;
  int          t[2] = '{-1, -1};
  bit          pend[2] = '{1'b0, 1'b0};
  logic [47:0] mframe[2];
  logic [47:0] cap[2];
  int          ncap[2] = '{0, 0};
  logic        psclk[2] = '{1'b0, 1'b0};
  logic        platch[2] = '{1'b0, 1'b0};
  logic [47:0] exp_q[2][$];
  logic [47:0] lit_q[2][$];
  bit          end_req = 1'b0;
  bit          done = 1'b0;

  task automatic chk(input string name, input int i, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0d state=%s act=%h exp=%h @%0t",
               name, i, t[i], dbg_state[i].name(), act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int d, flen, k;
    logic eb, es, ed, el;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_busy", i, busy[i], 0);
        chk("rst_sclk", i, sclk[i], 0);
        chk("rst_sdata", i, sdata[i], 0);
        chk("rst_latch", i, latch[i], 0);
        t[i] = -1; pend[i] = 1'b0; ncap[i] = 0;
        psclk[i] = 1'b0; platch[i] = 1'b0;
        exp_q[i].delete();
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        d = (i == 0) ? DIV0 : DIV1;
        flen = 1 + 97 * d;
        if (t[i] == 0) begin
          mframe[i] = frame_of(i == 0);
          exp_q[i].push_back(mframe[i]);
        end
        eb = (t[i] >= 0); es = 1'b0; ed = 1'b0; el = 1'b0;
        if (t[i] >= 1 && t[i] <= 96 * d) begin
          k  = (t[i] - 1) / d;
          es = (k % 2) == 1;
          ed = mframe[i][47 - k / 2];
        end else if (t[i] > 96 * d) begin
          el = 1'b1;
        end
        chk("busy", i, busy[i], eb);
        chk("sclk", i, sclk[i], es);
        chk("sdata", i, sdata[i], ed);
        chk("latch", i, latch[i], el);

        // Scoreboard: the byte stream as the external registers would see it.
        if (sclk[i] && !psclk[i]) begin
          cap[i] = {cap[i][46:0], sdata[i]};
          ncap[i]++;
        end
        if (latch[i] && !platch[i]) begin
          chk("sb_bits", i, ncap[i], 48);
          chk("sb_expected", i, exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0) chk("sb_frame", i, cap[i], exp_q[i].pop_front());
          if (lit_q[i].size() > 0) chk("lit_frame", i, cap[i], lit_q[i].pop_front());
          ncap[i] = 0;
        end
        psclk[i]  = sclk[i];
        platch[i] = latch[i];

        if (t[i] >= 0) begin
          if (update) pend[i] = 1'b1;
          t[i]++;
          if (t[i] == flen) begin
            if (pend[i]) begin t[i] = 0; pend[i] = 1'b0; end
            else t[i] = -1;
          end
        end else if (update || pend[i]) begin
          t[i] = 0; pend[i] = 1'b0;
        end
      end
      if (end_req && !done) begin
        for (int i = 0; i < 2; i++) begin
          chk("drained_exp", i, exp_q[i].size(), 0);
          chk("drained_lit", i, lit_q[i].size(), 0);
        end
        done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse();
    update = 1'b1;
    cyc(1);
    update = 1'b0;
  endtask

  task automatic set_time(input int a, input int b, input int c, input int e,
                          input int f, input int g, input bit col);
    hh = 2'(a); hl = 4'(b); mh = 3'(c); ml = 4'(e); sh = 3'(f); sl = 4'(g);
    colon = col;
  endtask

  task automatic push_lit(input logic [47:0] f0, input logic [47:0] f1);
    lit_q[0].push_back(f0);
    lit_q[1].push_back(f1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc(5);
    rst_n = 1'b1;
    cyc(200);

    set_time(1, 2, 3, 4, 5, 6, 1'b1);
    push_lit(48'h06DB4FE66D7D, 48'h06DB4FE66D7D);
    pulse();
    cyc(300);

    set_time(0, 9, 5, 9, 5, 12, 1'b0);
    push_lit(48'h006F6D6F6D40, 48'h3F6F6D6F6D40);
    pulse();
    cyc(300);

    set_time(1, 2, 3, 4, 5, 6, 1'b1);
    push_lit(48'h06DB4FE66D7D, 48'h06DB4FE66D7D);
    push_lit(48'h06DB4FED6D7D, 48'h06DB4FED6D7D);
    pulse();
    cyc(30);
    pulse();
    ml = 4'd5;
    cyc(10);
    pulse();
    cyc(10);
    pulse();
    cyc(650);

    set_time(1, 0, 0, 0, 0, 0, 1'b0);
    pulse();
    cyc(40);
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    set_time(2, 3, 5, 9, 5, 8, 1'b0);
    push_lit(48'h5B4F6D6F6D7F, 48'h5B4F6D6F6D7F);
    pulse();
    cyc(300);

    end_req = 1'b1;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
